// File: rtl/down_sample_pkg.sv
// +----------------------------------------------------------------------------+
// | down_sample_pkg                                                            |
// | Shared types and constants for the down_sample average-pool compute stage. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package down_sample_pkg;

  localparam int NUM_CTRL_VARS  = 4;
  localparam int CTRL_W         = 16;
  // Four WIDTH-bit taps need two extra bits to hold their sum without loss.
  localparam int SUM_GUARD_BITS = 2;

  typedef logic [NUM_CTRL_VARS-1:0][CTRL_W-1:0] ctrl_vars_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic ctrl_vars_t pack_ctrl(input logic [CTRL_W-1:0] ch,
                                           input logic [CTRL_W-1:0] y,
                                           input logic [CTRL_W-1:0] x);
    ctrl_vars_t v;
    v[0] = '0;
    v[1] = ch;
    v[2] = y;
    v[3] = x;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avg_pool_loop_iter.sv
// +----------------------------------------------------------------------------+
// | avg_pool_loop_iter                                                         |
// | Three-level ch/y/x loop counter (x innermost) with enable, clear and a     |
// | last-iteration flag.                                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

import down_sample_pkg::*;

module avg_pool_loop_iter #(
  parameter int OUT_W = 32,
  parameter int OUT_H = 32,
  parameter int CH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  output logic [CTRL_W-1:0] x,
  output logic [CTRL_W-1:0] y,
  output logic [CTRL_W-1:0] ch,
  output logic              last
);

  localparam logic [CTRL_W-1:0] C_X_LAST  = CTRL_W'(OUT_W - 1);
  localparam logic [CTRL_W-1:0] C_Y_LAST  = CTRL_W'(OUT_H - 1);
  localparam logic [CTRL_W-1:0] C_CH_LAST = CTRL_W'(CH - 1);

  logic [CTRL_W-1:0] x_q, x_d;
  logic [CTRL_W-1:0] y_q, y_d;
  logic [CTRL_W-1:0] ch_q, ch_d;

  logic w_x_wrap;
  logic w_y_wrap;

  assign w_x_wrap = (x_q == C_X_LAST);
  assign w_y_wrap = (y_q == C_Y_LAST);

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    ch_d = ch_q;
    if (clear) begin
      x_d  = '0;
      y_d  = '0;
      ch_d = '0;
    end else if (en) begin
      x_d = w_x_wrap ? '0 : x_q + 1'b1;
      if (w_x_wrap) begin
        y_d = w_y_wrap ? '0 : y_q + 1'b1;
        if (w_y_wrap) begin
          ch_d = (ch_q == C_CH_LAST) ? '0 : ch_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      ch_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      ch_q <= ch_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign ch   = ch_q;
  assign last = w_x_wrap & w_y_wrap & (ch_q == C_CH_LAST);

endmodule

`default_nettype wire

// File: rtl/avg_pool_2x2_compute.sv
// +----------------------------------------------------------------------------+
// | avg_pool_2x2_compute                                                       |
// | Walks ch/y/x, reads four 2x2 taps, writes one averaged pixel per output.   |
// | Build option: AVG_POOL_ROUND_EN selects round-half-up instead of truncate. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

import down_sample_pkg::*;

module avg_pool_2x2_compute #(
  parameter int OUT_W = 32,
  parameter int OUT_H = 32,
  parameter int CH    = 4,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_ren,
  output logic [3:0][15:0]      rd_ctrl_vars,
  input  logic [3:0][WIDTH-1:0] rd_data,
  output logic                  wr_wen,
  output logic [3:0][15:0]      wr_ctrl_vars,
  output logic [WIDTH-1:0]      wr_data
);

  localparam int SUM_W = WIDTH + SUM_GUARD_BITS;

  state_t            state_q, state_d;
  logic              s2_valid_q, s2_valid_d;
  ctrl_vars_t        wr_ctrl_q, wr_ctrl_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;

  logic [CTRL_W-1:0] w_x, w_y, w_ch;
  logic              w_last;
  logic [SUM_W-1:0]  w_sum;
  logic [WIDTH-1:0]  w_avg;

  avg_pool_loop_iter #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H),
    .CH    (CH)
  ) u_loop_iter (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .en    (rd_ren),
    .x     (w_x),
    .y     (w_y),
    .ch    (w_ch),
    .last  (w_last)
  );

  assign rd_ren       = (state_q == ST_RUN) & ~stall;
  assign rd_ctrl_vars = pack_ctrl(w_ch, w_y, w_x);
  assign wr_wen       = s2_valid_q & ~stall;

  assign w_sum = SUM_W'(rd_data[0]) + SUM_W'(rd_data[1])
               + SUM_W'(rd_data[2]) + SUM_W'(rd_data[3]);

`ifdef AVG_POOL_ROUND_EN
  assign w_avg = WIDTH'((w_sum + SUM_W'(2)) >> 2);
`else
  assign w_avg = WIDTH'(w_sum >> 2);
`endif

  always_comb begin
    state_d    = state_q;
    s2_valid_d = s2_valid_q;
    wr_ctrl_d  = wr_ctrl_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (rd_ren && w_last) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_wen || !s2_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A read behind the write keeps stage 2 occupied with the new result.
    if (rd_ren) begin
      s2_valid_d = 1'b1;
      wr_ctrl_d  = rd_ctrl_vars;
      wr_data_d  = w_avg;
    end else if (wr_wen) begin
      s2_valid_d = 1'b0;
    end

    if (flush) begin
      state_d    = ST_IDLE;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s2_valid_q <= 1'b0;
      wr_ctrl_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      s2_valid_q <= s2_valid_d;
      wr_ctrl_q  <= wr_ctrl_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign wr_ctrl_vars = wr_ctrl_q;
  assign wr_data      = wr_data_q;

endmodule

`default_nettype wire
